// File: rtl/cvxif_dot4_coproc_pkg.sv
// ============================================================================
// cvxif_dot4_pkg : shared types for the packed int8 dot-product coprocessor
// Rev 1.0
// ============================================================================
`default_nettype none

package cvxif_dot4_pkg;

    localparam int          XLEN_DEF       = 32;
    localparam int          ID_WIDTH_DEF   = 3;
    localparam int          DOT_W          = 18;
    localparam logic [6:0]  OPCODE_DEFAULT = 7'b0001011;

    typedef enum logic [2:0] {
        F3_DOT4  = 3'd0,
        F3_MAC4  = 3'd1,
        F3_ACCRD = 3'd2,
        F3_ACCWR = 3'd3
    } funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WAIT_COMMIT = 2'd1,
        ST_EXEC        = 2'd2,
        ST_RESP        = 2'd3
    } state_e;

    typedef struct packed {
        funct3_e                  funct3;
        logic                     clr;
        logic [4:0]               rd;
        logic [ID_WIDTH_DEF-1:0]  id;
        logic [XLEN_DEF-1:0]      rs1;
        logic [XLEN_DEF-1:0]      rs2;
    } req_t;

endpackage

`default_nettype wire

// File: rtl/cvxif_dot4_coproc_if.sv
// ============================================================================
// cvxif_dot4_coproc_if : issue / commit / result channels between core and coproc
// Rev 1.0
// ============================================================================
`default_nettype none

interface cvxif_dot4_coproc_if #(
    parameter int XLEN     = 32,
    parameter int ID_WIDTH = 3
);
    logic                issue_valid_i;
    logic                issue_ready_o;
    logic [31:0]         issue_instr_i;
    logic [ID_WIDTH-1:0] issue_id_i;
    logic [XLEN-1:0]     issue_rs1_i;
    logic [XLEN-1:0]     issue_rs2_i;
    logic                issue_accept_o;
    logic                issue_writeback_o;
    logic                commit_valid_i;
    logic [ID_WIDTH-1:0] commit_id_i;
    logic                commit_kill_i;
    logic                result_valid_o;
    logic                result_ready_i;
    logic [ID_WIDTH-1:0] result_id_o;
    logic [XLEN-1:0]     result_data_o;
    logic [4:0]          result_rd_o;
    logic                result_we_o;

    modport master (
        output issue_valid_i, issue_instr_i, issue_id_i, issue_rs1_i, issue_rs2_i,
               commit_valid_i, commit_id_i, commit_kill_i, result_ready_i,
        input  issue_ready_o, issue_accept_o, issue_writeback_o,
               result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o
    );

    modport slave (
        input  issue_valid_i, issue_instr_i, issue_id_i, issue_rs1_i, issue_rs2_i,
               commit_valid_i, commit_id_i, commit_kill_i, result_ready_i,
        output issue_ready_o, issue_accept_o, issue_writeback_o,
               result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o
    );
endinterface

`default_nettype wire

// File: rtl/cvxif_dot4_coproc_dot4_s8.sv
// ============================================================================
// dot4_s8 : combinational 4-lane signed int8 dot product, 18-bit signed sum
// Rev 1.0
// ============================================================================
`default_nettype none

module dot4_s8
    import cvxif_dot4_pkg::*;
(
    input  logic [31:0]             a,
    input  logic [31:0]             b,
    output logic signed [DOT_W-1:0] sum
);

    logic signed [15:0] prod [4];

    always_comb begin
        sum = '0;
        for (int k = 0; k < 4; k++) begin
            prod[k] = 16'($signed(a[8*k +: 8])) * 16'($signed(b[8*k +: 8]));
            sum     = sum + DOT_W'(prod[k]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/cvxif_dot4_coproc.sv
// ============================================================================
// cvxif_dot4_coproc : CV-X-IF responder for int8 DOT4 / MAC4 with private acc
// Rev 1.0
// ============================================================================
`default_nettype none

module cvxif_dot4_coproc
    import cvxif_dot4_pkg::*;
#(
    parameter int         XLEN     = XLEN_DEF,
    parameter int         ID_WIDTH = ID_WIDTH_DEF,
    parameter logic [6:0] OPCODE   = OPCODE_DEFAULT
)(
    input  logic              clk_i,
    input  logic              rst_ni,
    cvxif_dot4_coproc_if.slave xif,
    output logic              busy_o
);

    state_e                  state;
    req_t                    req;
    logic [XLEN-1:0]         acc;
    logic                    issue_ready;
    logic                    result_valid;
    logic [ID_WIDTH-1:0]     result_id;
    logic [XLEN-1:0]         result_data;
    logic [4:0]              result_rd;
    logic                    result_we;

    logic [2:0]              f3;
    logic                    accept;
    logic signed [DOT_W-1:0] dot;
    logic [XLEN-1:0]         dot_ext;
    logic [XLEN-1:0]         mac;

    // Decode is purely combinational so the core sees accept in the offer cycle
    assign f3     = xif.issue_instr_i[14:12];
    assign accept = xif.issue_valid_i && (xif.issue_instr_i[6:0] == OPCODE) && !f3[2];

    assign xif.issue_accept_o    = accept;
    assign xif.issue_writeback_o = accept && (f3 != F3_ACCWR);

    dot4_s8 u_dot4 (
        .a   (req.rs1),
        .b   (req.rs2),
        .sum (dot)
    );

    assign dot_ext = XLEN'(dot);
    assign mac     = acc + dot_ext;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state        <= ST_IDLE;
            req          <= '0;
            acc          <= '0;
            issue_ready  <= 1'b1;
            result_valid <= 1'b0;
            result_id    <= '0;
            result_data  <= '0;
            result_rd    <= '0;
            result_we    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (xif.issue_valid_i && issue_ready && accept) begin
                        req <= '{funct3: funct3_e'(f3),
                                 clr:    xif.issue_instr_i[25],
                                 rd:     xif.issue_instr_i[11:7],
                                 id:     xif.issue_id_i,
                                 rs1:    xif.issue_rs1_i,
                                 rs2:    xif.issue_rs2_i};
                        issue_ready <= 1'b0;
                        state       <= ST_WAIT_COMMIT;
                    end
                end
                ST_WAIT_COMMIT: begin
                    if (xif.commit_valid_i && (xif.commit_id_i == req.id)) begin
                        if (xif.commit_kill_i) begin
                            issue_ready <= 1'b1;
                            state       <= ST_IDLE;
                        end else begin
                            state <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    result_id <= req.id;
                    result_rd <= req.rd;
                    result_we <= 1'b1;
                    case (req.funct3)
                        F3_DOT4:  result_data <= dot_ext;
                        F3_MAC4: begin
                            acc         <= mac;
                            result_data <= mac;
                        end
                        F3_ACCRD: begin
                            result_data <= acc;
                            if (req.clr) acc <= '0;
                        end
                        F3_ACCWR: acc <= req.rs1;
                        default: ;
                    endcase
                    if (req.funct3 == F3_ACCWR) begin
                        issue_ready <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        result_valid <= 1'b1;
                        state        <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (xif.result_ready_i) begin
                        result_valid <= 1'b0;
                        issue_ready  <= 1'b1;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign xif.issue_ready_o  = issue_ready;
    assign xif.result_valid_o = result_valid;
    assign xif.result_id_o    = result_id;
    assign xif.result_data_o  = result_data;
    assign xif.result_rd_o    = result_rd;
    assign xif.result_we_o    = result_we;
    assign busy_o             = (state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_cvxif_dot4_coproc.sv
// ============================================================================
// tb_cvxif_dot4_coproc : randomized scoreboard bench for the dot4 coprocessor
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cvxif_dot4_coproc;
    import cvxif_dot4_pkg::*;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    logic busy_o;

    always #5 clk_i = ~clk_i;

    cvxif_dot4_coproc_if #(.XLEN(32), .ID_WIDTH(3)) xif ();

    cvxif_dot4_coproc #(.XLEN(32), .ID_WIDTH(3), .OPCODE(7'b0001011)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .xif    (xif),
        .busy_o (busy_o)
    );

    typedef struct {
        logic [31:0] data;
        logic [2:0]  id;
        logic [4:0]  rd;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic [31:0] acc_m;
    int          checks = 0;
    int          errors = 0;
    bit          rr_hold = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the four signed byte lanes
    function automatic logic [31:0] dot_ref(input logic [31:0] a, input logic [31:0] b);
        int  s;
        byte x, y;
        s = 0;
        for (int k = 0; k < 4; k++) begin
            x = a[8*k +: 8];
            y = b[8*k +: 8];
            s += int'(x) * int'(y);
        end
        return s;
    endfunction

    function automatic logic [31:0] mk(input logic [2:0] f3, input bit clr,
                                       input logic [4:0] rd, input logic [6:0] opc);
        logic [31:0] w;
        w        = $urandom;
        w[25]    = clr;
        w[14:12] = f3;
        w[11:7]  = rd;
        w[6:0]   = opc;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_issue(input logic [31:0] instr, input logic [2:0] id,
                            input logic [31:0] a, input logic [31:0] b);
        int n;
        tick();
        xif.issue_valid_i = 1'b1;
        xif.issue_instr_i = instr;
        xif.issue_id_i    = id;
        xif.issue_rs1_i   = a;
        xif.issue_rs2_i   = b;
        #1;
        chk("issue_accept", {31'd0, xif.issue_accept_o}, 32'd1);
        chk("issue_writeback", {31'd0, xif.issue_writeback_o}, {31'd0, instr[14:12] != 3'd3});
        n = 0;
        while (xif.issue_ready_o !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("issue_ready_timeout", 32'd0, 32'd1);
        tick();
        xif.issue_valid_i = 1'b0;
    endtask

    task automatic do_commit(input logic [2:0] id, input bit kill, input int dly);
        repeat (dly) tick();
        xif.commit_valid_i = 1'b1;
        xif.commit_id_i    = id;
        xif.commit_kill_i  = kill;
        tick();
        xif.commit_valid_i = 1'b0;
        xif.commit_kill_i  = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] f3, input bit clr, input logic [4:0] rd,
                          input logic [2:0] id, input logic [31:0] a, input logic [31:0] b,
                          input bit kill, input int dly, input bit stray);
        exp_t e;
        do_issue(mk(f3, clr, rd, 7'b0001011), id, a, b);
        if (stray) do_commit(id ^ 3'd1, 1'($urandom_range(0, 1)), 0);
        if (!kill) begin
            e.id = id;
            e.rd = rd;
            case (f3)
                3'd0: begin e.data = dot_ref(a, b); q.push_back(e); end
                3'd1: begin acc_m = acc_m + dot_ref(a, b); e.data = acc_m; q.push_back(e); end
                3'd2: begin e.data = acc_m; q.push_back(e); if (clr) acc_m = 32'd0; end
                default: acc_m = a;
            endcase
        end
        do_commit(id, kill, dly);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || busy_o) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_result_valid();
        int n;
        n = 0;
        while (xif.result_valid_o !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("result_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_reset();
        tick();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        q.delete();
        acc_m = 32'd0;
        chk("rst_issue_ready", {31'd0, xif.issue_ready_o}, 32'd1);
        chk("rst_result_valid", {31'd0, xif.result_valid_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
    endtask

    // Result-ready driver: random back-pressure unless held low
    initial begin
        xif.result_ready_i = 1'b0;
        forever begin
            tick();
            xif.result_ready_i = rr_hold ? 1'b0 : 1'($urandom_range(0, 1));
        end
    end

    // Monitor: pops the scoreboard whenever a result handshake is about to occur
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_ni && xif.result_valid_o && xif.result_ready_i) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", {29'd0, xif.result_id_o}, 32'hFFFF_FFFF);
                end else begin
                    mon_e = q.pop_front();
                    chk("result_data", xif.result_data_o, mon_e.data);
                    chk("result_id", {29'd0, xif.result_id_o}, {29'd0, mon_e.id});
                    chk("result_rd", {27'd0, xif.result_rd_o}, {27'd0, mon_e.rd});
                    chk("result_we", {31'd0, xif.result_we_o}, 32'd1);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        xif.issue_valid_i  = 1'b0;
        xif.issue_instr_i  = '0;
        xif.issue_id_i     = '0;
        xif.issue_rs1_i    = '0;
        xif.issue_rs2_i    = '0;
        xif.commit_valid_i = 1'b0;
        xif.commit_id_i    = '0;
        xif.commit_kill_i  = 1'b0;
        acc_m = 32'd0;

        repeat (3) tick();
        chk("reset_issue_ready", {31'd0, xif.issue_ready_o}, 32'd1);
        chk("reset_result_valid", {31'd0, xif.result_valid_o}, 32'd0);
        chk("reset_result_data", xif.result_data_o, 32'd0);
        chk("reset_result_id", {29'd0, xif.result_id_o}, 32'd0);
        chk("reset_result_rd", {27'd0, xif.result_rd_o}, 32'd0);
        chk("reset_result_we", {31'd0, xif.result_we_o}, 32'd0);
        chk("reset_busy", {31'd0, busy_o}, 32'd0);
        rst_ni = 1'b1;

        // Directed: DOT4 corner lanes, then confirm acc untouched
        run_op(3'd0, 1'b0, 5'd10, 3'd2, 32'h01FF_7F80, 32'h0202_7F80, 1'b0, 0, 1'b0);
        drain();
        run_op(3'd2, 1'b0, 5'd11, 3'd3, 32'd0, 32'd0, 1'b0, 0, 1'b0);
        drain();

        // Directed: MAC4 wrap from -4
        run_op(3'd3, 1'b0, 5'd0, 3'd1, 32'hFFFF_FFFC, 32'd0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            run_op(3'd1, 1'b0, 5'd5, 3'(i), 32'h0101_0101, 32'h0101_0101, 1'b0, 0, 1'b0);
            drain();
        end

        // Directed: ACCRD with clear, then plain ACCRD
        run_op(3'd3, 1'b0, 5'd0, 3'd4, 32'h0000_1234, 32'd0, 1'b0, 0, 1'b0);
        run_op(3'd2, 1'b1, 5'd7, 3'd5, 32'd0, 32'd0, 1'b0, 0, 1'b0);
        run_op(3'd2, 1'b0, 5'd8, 3'd6, 32'd0, 32'd0, 1'b0, 0, 1'b0);
        drain();

        // Directed: killed MAC4 leaves acc alone
        run_op(3'd3, 1'b0, 5'd0, 3'd0, 32'h0000_00AA, 32'd0, 1'b0, 0, 1'b0);
        run_op(3'd1, 1'b0, 5'd3, 3'd1, 32'h7F7F_7F7F, 32'h7F7F_7F7F, 1'b1, 1, 1'b0);
        run_op(3'd2, 1'b0, 5'd4, 3'd2, 32'd0, 32'd0, 1'b0, 0, 1'b0);
        drain();

        // Directed: foreign opcode and unsupported funct3 are not claimed
        for (int i = 0; i < 2; i++) begin
            tick();
            xif.issue_valid_i = 1'b1;
            xif.issue_instr_i = (i == 0) ? mk(3'd0, 1'b0, 5'd1, 7'h33) : mk(3'd5, 1'b0, 5'd1, 7'b0001011);
            #1;
            chk("foreign_accept", {31'd0, xif.issue_accept_o}, 32'd0);
            chk("foreign_writeback", {31'd0, xif.issue_writeback_o}, 32'd0);
            tick();
            chk("foreign_ready", {31'd0, xif.issue_ready_o}, 32'd1);
            chk("foreign_busy", {31'd0, busy_o}, 32'd0);
            xif.issue_valid_i = 1'b0;
        end

        // Directed: back-pressure holds result stable
        rr_hold = 1'b1;
        repeat (2) tick();
        run_op(3'd0, 1'b0, 5'd9, 3'd7, 32'h8080_8080, 32'h7F80_017F, 1'b0, 0, 1'b0);
        wait_result_valid();
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", {31'd0, xif.result_valid_o}, 32'd1);
            chk("hold_data", xif.result_data_o, q[0].data);
            chk("hold_rd", {27'd0, xif.result_rd_o}, {27'd0, q[0].rd});
            chk("hold_id", {29'd0, xif.result_id_o}, {29'd0, q[0].id});
            chk("hold_issue_ready", {31'd0, xif.issue_ready_o}, 32'd0);
            tick();
        end
        rr_hold = 1'b0;
        drain();

        // Directed: reset in WAIT_COMMIT, stale commit afterwards is ignored
        run_op(3'd3, 1'b0, 5'd0, 3'd0, 32'hDEAD_BEEF, 32'd0, 1'b0, 0, 1'b0);
        do_issue(mk(3'd1, 1'b0, 5'd2, 7'b0001011), 3'd5, 32'h0101_0101, 32'h0101_0101);
        pulse_reset();
        do_commit(3'd5, 1'b0, 0);
        repeat (4) tick();
        chk("stale_busy", {31'd0, busy_o}, 32'd0);
        chk("stale_valid", {31'd0, xif.result_valid_o}, 32'd0);
        run_op(3'd2, 1'b0, 5'd12, 3'd1, 32'd0, 32'd0, 1'b0, 0, 1'b0);
        drain();

        // Directed: reset while a result is pending
        run_op(3'd3, 1'b0, 5'd0, 3'd2, 32'h0000_0055, 32'd0, 1'b0, 0, 1'b0);
        rr_hold = 1'b1;
        repeat (2) tick();
        run_op(3'd0, 1'b0, 5'd13, 3'd3, 32'h0102_0304, 32'h0506_0708, 1'b0, 0, 1'b0);
        wait_result_valid();
        pulse_reset();
        chk("resp_rst_data", xif.result_data_o, 32'd0);
        rr_hold = 1'b0;
        run_op(3'd2, 1'b0, 5'd14, 3'd4, 32'd0, 32'd0, 1'b0, 0, 1'b0);
        drain();

        // Randomized mix
        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) a = 32'h8080_7F80;
            if ($urandom_range(0, 3) == 0) b = 32'h807F_8080;
            run_op(3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                   3'($urandom_range(0, 7)), a, b, ($urandom_range(0, 4) == 0),
                   $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) == 0) drain();
        end
        drain();
        run_op(3'd2, 1'b0, 5'd31, 3'd7, 32'd0, 32'd0, 1'b0, 0, 1'b0);
        drain();
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
